dmux_8_way_16_router: RTL and testbench
=======================================

Name: dmux_8_way_16_router

Overview:
Registered 1-to-8 distributor for 16-bit words. It is the write-side counterpart of the 8-way 16-bit selector: one valid/ready input stream is routed by a 3-bit select into one of eight output slots. Each slot is a one-entry register with its own valid/ready handshake. A broadcast mode writes the same word into all slots at once.

Parameters:
WIDTH, 16, data word width in bits
WAYS, 8, number of output channels; must be a power of two, at least 2
SEL_W, $clog2(WAYS), select width (localparam, derived, not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  WIDTH  word to route
in_sel  input  SEL_W  destination channel; ignored when in_bcast=1
in_bcast  input  1  broadcast: write word to every channel
in_valid  input  1  input word is present
in_ready  output  1  router accepts this cycle
out_data  output  WAYS*WIDTH  channel k data at [k*WIDTH +: WIDTH]
out_valid  output  WAYS  channel k slot holds a word
out_ready  input  WAYS  channel k consumer takes the word
accept_count  output  16  number of accepted input transfers, wraps

Behaviour:
- Reset: asynchronous on rst_n low.
  - out_valid=0, out_data=0, accept_count=0.
  - in_ready=0 while rst_n is low.
  - Words held mid-operation are discarded. No transfer completes in the cycle rst_n rises.
- Slot free condition: slot k is free when !out_valid[k] || out_ready[k], so a slot can be drained and refilled in the same cycle.
- in_ready (combinational from slot state, in_sel, in_bcast and out_ready; no dependence on in_valid):
  - in_bcast=0: in_ready = free(in_sel).
  - in_bcast=1: in_ready = AND of free(k) over all k.
- Accept = in_valid && in_ready. Latency 1: the word appears on out_data/out_valid the cycle after acceptance.
  - Unicast: slot in_sel loads in_data and sets valid. Other slots are untouched.
  - Broadcast: every slot loads in_data and sets valid in one cycle. Broadcast is all-or-nothing; no partial write occurs.
- Drain: out_valid[k] && out_ready[k] with no load into slot k clears valid[k]. out_data[k] holds its last value; it is not cleared.
- Drain and load to the same slot in the same cycle: the load wins, valid stays 1 and the new data is presented. This is not an overflow.
- Stability: while out_valid[k]=1 && out_ready[k]=0, out_data[k] must not change.
- Ignored inputs: in_sel is ignored when in_bcast=1. out_ready[k] has no effect when out_valid[k]=0.
- accept_count: +1 per accept, broadcast counts once. Wraps 16'hFFFF -> 16'h0000.
- Full: a slot full and not being drained blocks unicasts to it and blocks all broadcasts. Unicasts to other free slots proceed.
- No combinational path from in_valid to any output. The out_ready -> in_ready combinational path is permitted and documented.

Decomposition:
- Shared package dmux_pkg holds:
  - default WIDTH and WAYS constants;
  - SEL_W as a derived constant;
  - the count width (16);
  - a helper function slot_lo(k) returning k*WIDTH.
- Sub-module dmux_slot is the one-entry register:
  - ports: clk, rst_n, load, d, ready; outputs q, valid, free;
  - instantiated WAYS times in a generate loop.
- The top level holds only the select decode, the broadcast AND and the counter.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> in_ready=0, out_valid=8'h00, accept_count=0. Release -> in_ready=1 on the next cycle.
- Unicast sweep, out_ready=8'hFF:
  - inputs: sel 0..7 with 16'h5555, AAAA, 00FF, FF00, 3333, CCCC, 0F0F, F0F0 on consecutive cycles;
  - required: each word appears one cycle later on only its channel, one-hot out_valid;
  - required: accept_count=8.
- Backpressure: out_ready=0, send 16'h1234 to sel 3, then 16'hBEEF to sel 3.
  - Second word sees in_ready=0; channel 3 holds 16'h1234.
  - Raise out_ready[3] -> 16'hBEEF is accepted in that same cycle and appears on the next cycle with valid still 1.
- Independence: channel 2 is full and stalled; a unicast to sel 5 is accepted, and channel 2 data is unchanged.
- Broadcast: all slots empty, in_bcast=1, 16'hC3C3 -> all out_valid=8'hFF, all data C3C3, accept_count +1. Repeat with channel 6 stalled and full -> in_ready=0 and no slot changes.
- Wrap and mid-reset:
  - preload accept_count to 16'hFFFF via 65535 accepts; one more accept -> 16'h0000;
  - assert rst_n low while slots are full -> out_valid=0 immediately (asynchronous), without waiting for a clock edge.

Source files
------------

// File: rtl/dmux_pkg.sv
// Shared constants and helpers for the 8-way 16-bit router and its slot registers.
package dmux_pkg;

    localparam int DMUX_WIDTH = 16;
    localparam int DMUX_WAYS  = 8;
    localparam int DMUX_SEL_W = $clog2(DMUX_WAYS);
    localparam int COUNT_W    = 16;

    // Low bit index of channel k inside the packed out_data bus.
    function automatic int slot_lo(input int k, input int width = DMUX_WIDTH);
        return k * width;
    endfunction

endpackage

// File: rtl/dmux_slot.sv
// One-entry output register with valid/ready handshake; a load always beats a drain.
module dmux_slot
    import dmux_pkg::*;
#(
    parameter int WIDTH = DMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             ready,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             free
);

    logic [WIDTH-1:0] q_r;
    logic             valid_r;

    // Slot storage: load sets valid, drain clears valid but keeps the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r     <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else if (load) begin
            q_r     <= d;
            valid_r <= 1'b1;
        end else if (ready) begin
            valid_r <= 1'b0;
        end
    end

    assign q     = q_r;
    assign valid = valid_r;
    // Free also when the consumer drains this cycle, allowing drain-and-refill.
    assign free  = !valid_r || ready;

endmodule

// File: rtl/dmux_8_way_16_router.sv
// Registered 1-to-N distributor: select decode, broadcast gating and accept counter over N slots.
module dmux_8_way_16_router
    import dmux_pkg::*;
#(
    parameter int   WIDTH = DMUX_WIDTH,
    parameter int   WAYS  = DMUX_WAYS,
    localparam int  SEL_W = $clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_bcast,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WAYS*WIDTH-1:0] out_data,
    output logic [WAYS-1:0]       out_valid,
    input  logic [WAYS-1:0]       out_ready,
    output logic [COUNT_W-1:0]    accept_count
);

    logic [WAYS-1:0]    free_s;
    logic [WAYS-1:0]    load_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               run_r;
    logic [COUNT_W-1:0] count_r;

    // Holds in_ready low through reset and the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // Ready depends on slot state and out_ready only; in_valid never feeds an output.
    always_comb begin
        in_ready_s = 1'b0;
        if (!run_r) begin
            in_ready_s = 1'b0;
        end else if (in_bcast) begin
            in_ready_s = &free_s;
        end else begin
            in_ready_s = free_s[in_sel];
        end
    end

    assign accept_s = in_valid && in_ready_s;
    assign in_ready = in_ready_s;

    // Select decode: broadcast loads every slot, otherwise only the selected one.
    always_comb begin
        load_s = {WAYS{1'b0}};
        for (int k = 0; k < WAYS; k++) begin
            if (in_bcast) begin
                load_s[k] = accept_s;
            end else begin
                load_s[k] = accept_s && (in_sel == SEL_W'(k));
            end
        end
    end

    // Accept counter, broadcast counts once, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {COUNT_W{1'b0}};
        end else if (accept_s) begin
            count_r <= count_r + COUNT_W'(1);
        end
    end

    assign accept_count = count_r;

    for (genvar k = 0; k < WAYS; k++) begin : g_slot
        dmux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load_s[k]),
            .d     (in_data),
            .ready (out_ready[k]),
            .q     (out_data[slot_lo(k, WIDTH) +: WIDTH]),
            .valid (out_valid[k]),
            .free  (free_s[k])
        );
    end

endmodule

// File: tb/tb_dmux_8_way_16_router.sv
// Directed self-checking bench for dmux_8_way_16_router with hand-computed expectations.
module tb_dmux_8_way_16_router;

    logic         clk;
    logic         rst_n;
    logic [15:0]  in_data;
    logic [2:0]   in_sel;
    logic         in_bcast;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready;
    logic [15:0]  accept_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] sweep_tbl [8] = '{16'h5555, 16'hAAAA, 16'h00FF, 16'hFF00,
                                   16'h3333, 16'hCCCC, 16'h0F0F, 16'hF0F0};

    dmux_8_way_16_router dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_sel       (in_sel),
        .in_bcast     (in_bcast),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .accept_count (accept_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] chan(input int k);
        return out_data[k*16 +: 16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic b, input logic [2:0] s, input logic [15:0] d);
        in_valid = v;
        in_bcast = b;
        in_sel   = s;
        in_data  = d;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 8'hFF;
        drive(1'b1, 1'b0, 3'd0, 16'h1111);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {24'd0, out_valid}, 32'h00);
        chk("rst_count", {16'd0, accept_count}, 32'd0);
        chk("rst_data0", {16'd0, chan(0)}, 32'd0);

        // Release: no transfer on the first edge after reset rises.
        rst_n = 1'b1;
        #1;
        chk("release_not_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        tick();
        chk("release_ready", {31'd0, in_ready}, 32'd1);
        chk("release_count", {16'd0, accept_count}, 32'd0);

        // Unicast sweep with consumers always ready.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 3'(i), sweep_tbl[i]);
            #1;
            chk("sweep_ready", {31'd0, in_ready}, 32'd1);
            tick();
            chk("sweep_onehot", {24'd0, out_valid}, 32'd1 << i);
            chk("sweep_data", {16'd0, chan(i)}, {16'd0, sweep_tbl[i]});
        end
        in_valid = 1'b0;
        tick();
        chk("sweep_count", {16'd0, accept_count}, 32'd8);
        chk("sweep_drained", {24'd0, out_valid}, 32'h00);

        // Backpressure on channel 3.
        out_ready = 8'h00;
        drive(1'b1, 1'b0, 3'd3, 16'h1234);
        tick();
        chk("bp_valid", {24'd0, out_valid}, 32'h08);
        chk("bp_data_first", {16'd0, chan(3)}, 32'h1234);
        drive(1'b1, 1'b0, 3'd3, 16'hBEEF);
        #1;
        chk("bp_blocked", {31'd0, in_ready}, 32'd0);
        tick();
        chk("bp_hold", {16'd0, chan(3)}, 32'h1234);
        chk("bp_count_hold", {16'd0, accept_count}, 32'd9);
        out_ready = 8'h08;
        #1;
        chk("bp_drain_refill_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid  = 1'b0;
        out_ready = 8'h00;
        chk("bp_refill_valid", {24'd0, out_valid}, 32'h08);
        chk("bp_refill_data", {16'd0, chan(3)}, 32'hBEEF);
        chk("bp_count", {16'd0, accept_count}, 32'd10);

        // Independence: channel 2 stalled full, unicast to channel 5 proceeds.
        drive(1'b1, 1'b0, 3'd2, 16'h2222);
        tick();
        drive(1'b1, 1'b0, 3'd5, 16'h5A5A);
        #1;
        chk("ind_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("ind_valid", {24'd0, out_valid}, 32'h2C);
        chk("ind_ch2", {16'd0, chan(2)}, 32'h2222);
        chk("ind_ch5", {16'd0, chan(5)}, 32'h5A5A);
        chk("ind_count", {16'd0, accept_count}, 32'd12);
        out_ready = 8'hFF;
        tick();
        chk("ind_drained", {24'd0, out_valid}, 32'h00);

        // Broadcast into empty slots; in_sel is ignored.
        out_ready = 8'h00;
        drive(1'b1, 1'b1, 3'd3, 16'hC3C3);
        #1;
        chk("bc_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bc_valid", {24'd0, out_valid}, 32'hFF);
        for (int k = 0; k < 8; k++) begin
            chk("bc_data", {16'd0, chan(k)}, 32'hC3C3);
        end
        chk("bc_count", {16'd0, accept_count}, 32'd13);
        out_ready = 8'hFF;
        tick();

        // Broadcast blocked by stalled full channel 6.
        out_ready = 8'h00;
        drive(1'b1, 1'b0, 3'd6, 16'h6666);
        tick();
        out_ready = 8'hBF;
        drive(1'b1, 1'b1, 3'd0, 16'h9999);
        #1;
        chk("bc_blocked", {31'd0, in_ready}, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("bc_blk_valid", {24'd0, out_valid}, 32'h40);
        chk("bc_blk_ch6", {16'd0, chan(6)}, 32'h6666);
        chk("bc_blk_ch0", {16'd0, chan(0)}, 32'hC3C3);
        chk("bc_blk_count", {16'd0, accept_count}, 32'd14);

        // Counter wrap: bring count to FFFF, then one more accept.
        out_ready = 8'hFF;
        drive(1'b1, 1'b0, 3'd0, 16'h0001);
        repeat (65535 - 14) tick();
        chk("wrap_max", {16'd0, accept_count}, 32'hFFFF);
        tick();
        chk("wrap_zero", {16'd0, accept_count}, 32'h0000);
        in_valid = 1'b0;
        tick();

        // Mid-operation asynchronous reset with all slots full.
        out_ready = 8'h00;
        drive(1'b1, 1'b1, 3'd0, 16'h7777);
        tick();
        in_valid = 1'b0;
        chk("mid_full", {24'd0, out_valid}, 32'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_valid", {24'd0, out_valid}, 32'h00);
        chk("mid_async_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_async_data", {16'd0, chan(4)}, 32'h0000);
        chk("mid_async_count", {16'd0, accept_count}, 32'h0000);
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
